branch_predictor: RTL and testbench
===================================

BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter: ENTRIES, default 8, number of direct-mapped BTB entries (power of two, 4..64).
REQ-002 Parameter: IDXW, default 3, index width, equal to log2(ENTRIES).
REQ-003 Port: clk  input  1  single clock; all state changes on the rising edge.
REQ-004 Port: rst  input  1  reset, asynchronous, active-low.
REQ-005 Port: PCF  input  32  fetch-stage PC.
REQ-006 Port: PredTakenF  output  1  fetch prediction: branch predicted taken.
REQ-007 Port: PredTargetF  output  32  predicted target; valid when PredTakenF=1, else 0.
REQ-008 Port: BranchE  input  1  the execute-stage instruction is a branch whose outcome is resolved this cycle.
REQ-009 Port: BranchTakenE  input  1  resolved direction (condition passed).
REQ-010 Port: PCE  input  32  PC of the execute-stage branch.
REQ-011 Port: BranchTargetE  input  32  resolved branch target.
REQ-012 Port: PredTakenE  input  1  PredTakenF value carried down the pipeline with that instruction.
REQ-013 Port: PredTargetE  input  32  PredTargetF value carried down the pipeline with that instruction.
REQ-014 Port: MispredictE  output  1  the execute-stage branch was mispredicted; the pipeline flushes F/D/E younger instructions.
REQ-015 Port: RecoverPCE  output  32  correct next PC when MispredictE=1, else 0.
REQ-016 Port: MissCount  output  16  saturating mispredict counter.

Function
REQ-017 Index = PC[IDXW+1:2]; tag = PC[31:IDXW+2]; each entry holds valid, tag, 32-bit target, 2-bit counter.
REQ-018 Counter encoding: 00 strongly-not-taken, 01 weakly-not-taken, 10 weakly-taken, 11 strongly-taken.
REQ-019 Lookup is combinational: hit = valid & tag match at index(PCF); PredTakenF = hit & counter[1]; PredTargetF = stored target when PredTakenF=1.
REQ-020 Update occurs on the clock edge with BranchE=1 only; BranchE=0 leaves the table unchanged.
REQ-021 Hit on index(PCE): taken increments the counter, saturating at 11; not-taken decrements it, saturating at 00; when taken, the target is rewritten with BranchTargetE.
REQ-022 Miss, taken: allocate by setting valid=1, tag, target=BranchTargetE, counter=10, replacing any prior occupant.
REQ-023 Miss, not-taken: no allocation and no change.
REQ-024 MispredictE (combinational) = BranchE & ((PredTakenE != BranchTakenE) | (PredTakenE & BranchTakenE & PredTargetE != BranchTargetE)).
REQ-025 RecoverPCE = BranchTakenE ? BranchTargetE : PCE+4 (mod 2^32), gated to 0 when MispredictE=0.
REQ-026 MissCount increments by 1 on each edge where MispredictE=1, and holds at 16'hFFFF.
REQ-027 Simultaneous lookup and update of the same index in one cycle: the lookup returns the pre-edge contents (no bypass).
REQ-028 Prediction has zero-cycle latency and update has one-cycle latency: the updated entry is visible to lookups from the next cycle.

Reset
REQ-029 While rst=0, all valid bits=0, counters=01, targets=0, tags=0, and MissCount=0; outputs therefore read PredTakenF=0, PredTargetF=0, MispredictE=0 (given BranchE=0), and RecoverPCE=0.
REQ-030 Reset asserted mid-update aborts the update; no entry retains partial state after rst rises.

Verification
REQ-031 Reset, then PCF=0x00000010 -> PredTakenF=0, PredTargetF=0.
REQ-032 BranchE=1, PCE=0x10, BranchTakenE=1, target 0x40, PredTakenE=0 -> MispredictE=1, RecoverPCE=0x40, MissCount=1; next cycle PCF=0x10 -> PredTakenF=1, PredTargetF=0x40.
REQ-033 Same branch resolved not-taken twice with PredTakenE correct each time -> counter 10->01->00; PCF=0x10 -> PredTakenF=0; a taken resolution then gives 01 and still predicts not-taken.
REQ-034 Aliasing: entry for 0x10 valid; taken branch at 0x30 (same index, ENTRIES=8) -> entry replaced; PCF=0x10 -> miss, PredTakenF=0.
REQ-035 Target mismatch: PredTakenE=1, PredTargetE=0x40, BranchTakenE=1, BranchTargetE=0x80 -> MispredictE=1, RecoverPCE=0x80; not-taken with PredTakenE=1 at PCE=0xFFFFFFFC -> RecoverPCE=0x00000000.
REQ-036 Force 65540 mispredicts -> MissCount=0xFFFF; assert rst asynchronously mid-cycle -> MissCount=0 and all lookups miss immediately.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Combinational fetch lookup, execute-stage update/mispredict detection, miss counter.
module branch_predictor #(
  parameter int ENTRIES = 8,
  parameter int IDXW    = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PCF,
  output logic        PredTakenF,
  output logic [31:0] PredTargetF,
  input  logic        BranchE,
  input  logic        BranchTakenE,
  input  logic [31:0] PCE,
  input  logic [31:0] BranchTargetE,
  input  logic        PredTakenE,
  input  logic [31:0] PredTargetE,
  output logic        MispredictE,
  output logic [31:0] RecoverPCE,
  output logic [15:0] MissCount
);

  localparam int TAGW = 30 - IDXW;

  logic            validQ  [ENTRIES];
  logic [TAGW-1:0] tagQ    [ENTRIES];
  logic [31:0]     targetQ [ENTRIES];
  logic [1:0]      ctrQ    [ENTRIES];

  logic [IDXW-1:0] idxF, idxE;
  logic [TAGW-1:0] tagF, tagE;
  logic            hitF, hitE;
  logic [31:0]     seqPCE;

  assign idxF = PCF[IDXW+1:2];
  assign tagF = PCF[31:IDXW+2];
  assign idxE = PCE[IDXW+1:2];
  assign tagE = PCE[31:IDXW+2];

  // Lookup reads the registered table only, so a same-cycle update is not bypassed.
  assign hitF        = validQ[idxF] && (tagQ[idxF] == tagF);
  assign PredTakenF  = hitF && ctrQ[idxF][1];
  assign PredTargetF = PredTakenF ? targetQ[idxF] : 32'd0;

  assign hitE = validQ[idxE] && (tagQ[idxE] == tagE);

  assign MispredictE = BranchE && ((PredTakenE != BranchTakenE) ||
                       (PredTakenE && BranchTakenE && (PredTargetE != BranchTargetE)));

  assign seqPCE     = PCE + 32'd4;
  assign RecoverPCE = !MispredictE ? 32'd0 : (BranchTakenE ? BranchTargetE : seqPCE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        validQ[i]  <= 1'b0;
        tagQ[i]    <= '0;
        targetQ[i] <= 32'd0;
        ctrQ[i]    <= 2'b01;
      end
    end else if (BranchE) begin
      if (hitE) begin
        if (BranchTakenE) begin
          targetQ[idxE] <= BranchTargetE;
          if (ctrQ[idxE] != 2'b11) ctrQ[idxE] <= ctrQ[idxE] + 2'b01;
        end else if (ctrQ[idxE] != 2'b00) begin
          ctrQ[idxE] <= ctrQ[idxE] - 2'b01;
        end
      end else if (BranchTakenE) begin
        // Taken miss evicts whatever aliased into this slot.
        validQ[idxE]  <= 1'b1;
        tagQ[idxE]    <= tagE;
        targetQ[idxE] <= BranchTargetE;
        ctrQ[idxE]    <= 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      MissCount <= 16'd0;
    end else if (MispredictE && (MissCount != 16'hFFFF)) begin
      MissCount <= MissCount + 16'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: lookup, update, aliasing, mispredict
// recovery, counter saturation and asynchronous reset behaviour.
module tb_branch_predictor;

  logic        clk;
  logic        rst;
  logic [31:0] PCF;
  logic        PredTakenF;
  logic [31:0] PredTargetF;
  logic        BranchE;
  logic        BranchTakenE;
  logic [31:0] PCE;
  logic [31:0] BranchTargetE;
  logic        PredTakenE;
  logic [31:0] PredTargetE;
  logic        MispredictE;
  logic [31:0] RecoverPCE;
  logic [15:0] MissCount;

  int checks = 0;
  int errors = 0;
  int expMiss = 0;

  branch_predictor #(.ENTRIES(8), .IDXW(3)) dut (
    .clk(clk), .rst(rst), .PCF(PCF), .PredTakenF(PredTakenF), .PredTargetF(PredTargetF),
    .BranchE(BranchE), .BranchTakenE(BranchTakenE), .PCE(PCE), .BranchTargetE(BranchTargetE),
    .PredTakenE(PredTakenE), .PredTargetE(PredTargetE), .MispredictE(MispredictE),
    .RecoverPCE(RecoverPCE), .MissCount(MissCount)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic resolve(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                         input logic pt, input logic [31:0] ptgt);
    BranchE = 1'b1; PCE = pc; BranchTakenE = taken; BranchTargetE = tgt;
    PredTakenE = pt; PredTargetE = ptgt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    BranchE = 1'b0;
  endtask

  initial begin
    rst = 1'b0; PCF = 32'h10; BranchE = 0; BranchTakenE = 0; PCE = 0;
    BranchTargetE = 0; PredTakenE = 0; PredTargetE = 0;
    #12;
    check("reset_pred_taken", {31'd0, PredTakenF}, 32'd0);
    check("reset_pred_target", PredTargetF, 32'd0);
    check("reset_mispredict", {31'd0, MispredictE}, 32'd0);
    check("reset_recover", RecoverPCE, 32'd0);
    check("reset_misscount", {16'd0, MissCount}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // First taken resolution of 0x10: allocate with counter 10.
    resolve(32'h10, 1'b1, 32'h40, 1'b0, 32'h0);
    #1;
    check("alloc_mispredict", {31'd0, MispredictE}, 32'd1);
    check("alloc_recover", RecoverPCE, 32'h40);
    check("alloc_no_bypass", {31'd0, PredTakenF}, 32'd0);
    step(); expMiss++;
    check("alloc_misscount", {16'd0, MissCount}, expMiss);
    check("alloc_pred_taken", {31'd0, PredTakenF}, 32'd1);
    check("alloc_pred_target", PredTargetF, 32'h40);

    // Two correctly predicted not-taken resolutions: 10 -> 01 -> 00.
    resolve(32'h10, 1'b0, 32'h40, 1'b0, 32'h0);
    #1;
    check("nt_mispredict", {31'd0, MispredictE}, 32'd0);
    check("nt_recover", RecoverPCE, 32'd0);
    step();
    resolve(32'h10, 1'b0, 32'h40, 1'b0, 32'h0);
    step();
    check("nt_pred_taken", {31'd0, PredTakenF}, 32'd0);
    check("nt_pred_target", PredTargetF, 32'd0);
    check("nt_misscount", {16'd0, MissCount}, expMiss);
    // Taken from 00 gives 01: still not-taken.
    resolve(32'h10, 1'b1, 32'h40, 1'b0, 32'h0);
    step(); expMiss++;
    check("ctr01_pred_taken", {31'd0, PredTakenF}, 32'd0);
    // Another taken with a new target gives 10 and rewrites the target.
    resolve(32'h10, 1'b1, 32'h44, 1'b0, 32'h0);
    step(); expMiss++;
    check("ctr10_pred_taken", {31'd0, PredTakenF}, 32'd1);
    check("ctr10_pred_target", PredTargetF, 32'h44);
    check("ctr10_misscount", {16'd0, MissCount}, expMiss);

    // Aliasing: 0x30 shares index 4 with 0x10.
    resolve(32'h30, 1'b1, 32'h90, 1'b0, 32'h0);
    step(); expMiss++;
    check("alias_old_miss", {31'd0, PredTakenF}, 32'd0);
    PCF = 32'h30; #1;
    check("alias_new_taken", {31'd0, PredTakenF}, 32'd1);
    check("alias_new_target", PredTargetF, 32'h90);

    // Combinational mispredict/recovery cases.
    resolve(32'h30, 1'b1, 32'h80, 1'b1, 32'h40); #1;
    check("tgt_mismatch_mp", {31'd0, MispredictE}, 32'd1);
    check("tgt_mismatch_recover", RecoverPCE, 32'h80);
    resolve(32'h30, 1'b1, 32'h80, 1'b1, 32'h80); #1;
    check("tgt_match_mp", {31'd0, MispredictE}, 32'd0);
    check("tgt_match_recover", RecoverPCE, 32'd0);
    resolve(32'h100, 1'b0, 32'h80, 1'b1, 32'h80); #1;
    check("nt_seq_recover", RecoverPCE, 32'h104);
    resolve(32'hFFFFFFFC, 1'b0, 32'h80, 1'b1, 32'h80); #1;
    check("wrap_mp", {31'd0, MispredictE}, 32'd1);
    check("wrap_recover", RecoverPCE, 32'd0);
    BranchE = 1'b0; #1;
    check("no_branch_mp", {31'd0, MispredictE}, 32'd0);

    // Counter saturation at 11: three taken hits then one not-taken keeps 10.
    for (int i = 0; i < 3; i++) begin
      resolve(32'h30, 1'b1, 32'h90, 1'b1, 32'h90);
      step();
    end
    resolve(32'h30, 1'b0, 32'h90, 1'b1, 32'h90);
    step(); expMiss++;
    check("sat_hi_pred_taken", {31'd0, PredTakenF}, 32'd1);
    check("sat_hi_misscount", {16'd0, MissCount}, expMiss);

    // Reset during a pending update aborts it.
    resolve(32'h70, 1'b1, 32'hA0, 1'b0, 32'h0);
    #2 rst = 1'b0;
    @(posedge clk); #1;
    BranchE = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    PCF = 32'h70; #1;
    check("rst_abort_miss", {31'd0, PredTakenF}, 32'd0);
    PCF = 32'h30; #1;
    check("rst_clears_table", {31'd0, PredTakenF}, 32'd0);
    check("rst_clears_count", {16'd0, MissCount}, 32'd0);

    // Entry for 0x30 again, then flood mispredicts at a different index.
    @(posedge clk); #1;
    resolve(32'h30, 1'b1, 32'h90, 1'b1, 32'h90);
    step();
    check("realloc_taken", {31'd0, PredTakenF}, 32'd1);
    resolve(32'h200, 1'b0, 32'h0, 1'b1, 32'h0);
    for (int i = 0; i < 65540; i++) @(posedge clk);
    #1;
    check("sat_misscount", {16'd0, MissCount}, 32'h0000FFFF);
    #2 rst = 1'b0;
    #1;
    check("async_rst_count", {16'd0, MissCount}, 32'd0);
    check("async_rst_lookup", {31'd0, PredTakenF}, 32'd0);
    check("async_rst_target", PredTargetF, 32'd0);
    BranchE = 1'b0;
    #20;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
